// File: rtl/pll_lock_pkg.sv
// Shared types and widths for the PLL lock monitor.
package pll_lock_pkg;

  localparam int CNT_W  = 16;
  localparam int LOSS_W = 8;

  localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABILIZE = 2'd1,
    ST_RUN       = 2'd2,
    ST_LOST      = 2'd3
  } pll_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared by a synchronous reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_monitor.sv
// Holds downstream logic in reset until the PLL lock flag has been stable long enough,
// and counts lock losses seen while running.
module pll_lock_monitor
  import pll_lock_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES   = 64
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              locked,
  input  logic              clear_count,
  output logic              rst_out,
  output logic              ready,
  output logic              loss_event,
  output logic [LOSS_W-1:0] loss_count,
  output logic [1:0]        dbg_state
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  logic              w_locked_s;
  pll_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_loss_now;
  logic              r_rst_out;
  logic              r_ready;
  logic              r_loss_event;
  logic [LOSS_W-1:0] r_loss_count;

  sync_2ff u_sync (
    .i_clk (clock_in),
    .i_rst (reset),
    .i_d   (locked),
    .o_q   (w_locked_s)
  );

  // Outputs are re-registered from the state so rst_out/ready change together, one cycle after the state.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state      <= ST_WAIT_LOCK;
      r_cnt        <= '0;
      r_loss_now   <= 1'b0;
      r_rst_out    <= 1'b1;
      r_ready      <= 1'b0;
      r_loss_event <= 1'b0;
    end else begin
      r_loss_now   <= 1'b0;
      r_rst_out    <= (r_state != ST_RUN);
      r_ready      <= (r_state == ST_RUN);
      r_loss_event <= r_loss_now;
      case (r_state)
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            r_state <= ST_STABILIZE;
            r_cnt   <= '0;
          end
        end
        ST_STABILIZE: begin
          if (!w_locked_s) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STABLE_LAST) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!w_locked_s) begin
            r_state    <= ST_LOST;
            r_cnt      <= '0;
            r_loss_now <= 1'b1;
          end
        end
        ST_LOST: begin
          // The lock flag is deliberately ignored until the hold time has elapsed.
          if (r_cnt == HOLD_LAST) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_WAIT_LOCK;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // A clear that lands on a loss pulse still counts that loss.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_loss_count <= '0;
    end else if (clear_count) begin
      r_loss_count <= {{(LOSS_W-1){1'b0}}, r_loss_event};
    end else if (r_loss_event && (r_loss_count != LOSS_MAX)) begin
      r_loss_count <= r_loss_count + 1'b1;
    end
  end

  assign rst_out    = r_rst_out;
  assign ready      = r_ready;
  assign loss_event = r_loss_event;
  assign loss_count = r_loss_count;
  assign dbg_state  = r_state;

endmodule

// File: doc/pll_lock_monitor.md
PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before reset release; legal range 2..65535.
REQ-002 SHALL have parameter HOLD_CYCLES, default 64: minimum cycles rst_out stays high after a lock loss; legal range 1..65535.
REQ-003 SHALL have port clock_in, input, 1: single clock, the PLL output clock (100 MHz); all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port locked, input, 1: PLL lock flag, asynchronous to clock_in.
REQ-006 SHALL have port clear_count, input, 1: synchronous single-cycle request to zero loss_count.
REQ-007 SHALL have port rst_out, output, 1: active-high synchronous reset for downstream logic.
REQ-008 SHALL have port ready, output, 1: high only in RUN.
REQ-009 SHALL have port loss_event, output, 1: one-cycle pulse per detected lock loss.
REQ-010 SHALL have port loss_count, output, 8: saturating lock-loss counter.

Function
REQ-011 SHALL pass locked through a 2-flop synchronizer; locked_s is locked delayed 2 cycles, and only locked_s drives the FSM.
REQ-012 SHALL implement FSM states WAIT_LOCK, STABILIZE, RUN, LOST, with a 16-bit cycle counter cnt.
REQ-013 WAIT_LOCK: rst_out=1, ready=0; locked_s=1 -> STABILIZE with cnt=0.
REQ-014 STABILIZE: rst_out=1; cnt increments each cycle; locked_s=0 -> WAIT_LOCK with no loss_event and no count change.
REQ-015 STABILIZE: locked_s=1 and cnt==STABLE_CYCLES-1 -> RUN, so rst_out falls exactly STABLE_CYCLES+3 cycles after locked is first sampled high.
REQ-016 RUN: rst_out=0, ready=1; locked_s=0 -> LOST, with loss_event=1 for that transition cycle only and cnt=0.
REQ-017 LOST: rst_out=1, ready=0; cnt increments; cnt==HOLD_CYCLES-1 -> WAIT_LOCK regardless of locked_s, and locked_s is ignored until then.
REQ-018 loss_count SHALL increment on each loss_event and saturate at 255, with no wrap.
REQ-019 clear_count=1 SHALL zero loss_count next cycle; if it coincides with loss_event, the result SHALL be 1 (clear first, then count).
REQ-020 rst_out and ready SHALL be registered outputs, glitch-free, and never both high.

Reset
REQ-021 When reset=1, the next edge SHALL set: state=WAIT_LOCK, cnt=0, synchronizer flops=0, rst_out=1, ready=0, loss_event=0, loss_count=0.
REQ-022 Reset asserted mid-STABILIZE, RUN or LOST SHALL abort immediately with no loss_event, and the full STABLE_CYCLES qualification SHALL restart after release.

Structure
REQ-023 Shared package pll_lock_pkg SHALL hold the state enum, the counter width constant (16) and the loss_count width (8).
REQ-024 The synchronizer SHALL be one sub-module sync_2ff (1-bit, reset to 0); everything else SHALL stay flat in pll_lock_monitor.

Verification (STABLE_CYCLES=16, HOLD_CYCLES=8)
REQ-025 Reset, then locked=1 at cycle 0 -> rst_out falls and ready rises at cycle 19, and loss_count=0.
REQ-026 locked high for 10 cycles, then low, then high -> no ready and no loss_event; rst_out falls 19 cycles after the final rise.
REQ-027 In RUN, drop locked for 1 cycle -> loss_event pulses once 3 cycles later, loss_count=1, and rst_out stays high for at least 8 cycles, then requalifies for 16.
REQ-028 300 loss events -> loss_count stays at 255; then clear_count coincident with a loss -> loss_count=1.
REQ-029 reset pulse while in RUN with locked=1 -> rst_out=1 next cycle, loss_event=0, loss_count=0, ready returns 19 cycles after release.
REQ-030 Random locked toggling -> assertions hold throughout: ready implies !rst_out, loss_event never high for 2 consecutive cycles, and loss_count is monotonic except on clear/reset.
